data_memory_hs: RTL and testbench

- Parametrised, byte-addressed data memory for the RISC-V core's load/store unit.
- Successor to the single-cycle combinational-read word memory.
- Adds:
  - valid/ready request and response handshakes
  - configurable read latency
  - byte and halfword stores via byte lanes
  - sign/zero-extended sub-word loads
  - misalignment and out-of-range error reporting
- One outstanding request at a time.

---
 rtl/data_memory_hs.sv | 189 ++++++++++++++++++
 tb/tb_data_memory_hs.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_hs.sv
// data_memory_hs: byte-addressed data memory for the load/store unit with
// valid/ready request and response handshakes, a configurable read latency,
// byte-lane stores, sign/zero-extended sub-word loads and error reporting.
// Only one request is in flight at a time, so all accesses are serialised.
module data_memory_hs #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    // Value of the wait counter on the last WAIT cycle (unused when LATENCY == 1).
    localparam logic [1:0] CNT_LAST = 2'((LATENCY > 1) ? (LATENCY - 2) : 0);

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    // Reject illegal parameterisations at elaboration time.
    if ((DEPTH_WORDS < 4) || ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0)) begin : g_bad_depth
        $error("data_memory_hs: DEPTH_WORDS must be a power of two and at least 4");
    end
    if ((LATENCY < 1) || (LATENCY > 4)) begin : g_bad_latency
        $error("data_memory_hs: LATENCY must be in the range 1..4");
    end

    state_e         state_q, state_d;
    logic [1:0]     cnt_q, cnt_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           err_q, err_d;

    logic           accept;
    logic [1:0]     lane;
    logic [AW-1:0]  word_idx;
    logic           size_err;
    logic           align_err;
    logic           range_err;
    logic           req_err;
    logic [3:0]     byte_en;
    logic [31:0]    wdata_lanes;
    logic [31:0]    rd_word;
    logic [31:0]    rd_shifted;
    logic [31:0]    load_val;

    logic [31:0]    mem_q [DEPTH_WORDS];

    assign accept   = req_valid && req_ready;
    assign lane     = req_addr[1:0];
    assign word_idx = req_addr[AW+1:2];

    // Decode the request: error flags, byte enables and lane-replicated store data.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
        size_err    = 1'b0;
        align_err   = 1'b0;
        byte_en     = 4'b0000;
        wdata_lanes = req_wdata;
        unique case (req_size)
            SIZE_BYTE: begin
                byte_en     = 4'b0001 << lane;
                wdata_lanes = {4{req_wdata[7:0]}};
            end
            SIZE_HALF: begin
                align_err   = lane[0];
                byte_en     = 4'b0011 << {lane[1], 1'b0};
                wdata_lanes = {2{req_wdata[15:0]}};
            end
            SIZE_WORD: begin
                align_err   = (lane != 2'b00);
                byte_en     = 4'b1111;
            end
            default: begin
                size_err    = 1'b1;
            end
        endcase
        // The full upper address is compared, so out-of-range addresses never alias.
        range_err = (32'(req_addr[31:2]) >= 32'(DEPTH_WORDS));
        req_err   = size_err || align_err || range_err;
    end

    // Byte-lane store into the array at the acceptance edge.
    // NOTE: the array has no reset; its contents are undefined until written, which keeps it mappable to RAM.
    always_ff @(posedge clk) begin
        if (accept && req_write && !req_err) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem_q[word_idx][8*b +: 8] <= wdata_lanes[8*b +: 8];
                end
            end
        end
    end

    // Load path: shift the addressed lane down to bit 0 and extend it.
    always_comb begin
        rd_word    = mem_q[word_idx];
        rd_shifted = rd_word >> {lane, 3'b000};
        load_val   = rd_shifted;
        unique case (req_size)
            SIZE_BYTE: load_val = req_unsigned ? {24'h0, rd_shifted[7:0]}
                                               : {{24{rd_shifted[7]}}, rd_shifted[7:0]};
            SIZE_HALF: load_val = req_unsigned ? {16'h0, rd_shifted[15:0]}
                                               : {{16{rd_shifted[15]}}, rd_shifted[15:0]};
            default:   load_val = rd_shifted;
        endcase
    end

    // Response payload is captured once at acceptance and held until the handshake.
    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (accept) begin
            err_d   = req_err;
            rdata_d = (req_err || req_write) ? 32'h0 : load_val;
        end
    end

    // State register, wait counter and response payload registers.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: accept in IDLE, wait out the latency, hand off in RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d   = 2'd0;
                    state_d = (LATENCY > 1) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        req_ready  = (state_q == S_IDLE);
        resp_valid = (state_q == S_RESP);
        resp_rdata = rdata_q;
        resp_err   = err_q;
    end

endmodule

// File: tb/tb_data_memory_hs.sv
// tb_data_memory_hs: directed bench for data_memory_hs with a byte-level
// behavioural model. Instance 0 uses LATENCY=1, instance 1 uses LATENCY=3.
module tb_data_memory_hs;

    localparam int DEPTH = 256;
    localparam int MEM_BYTES = DEPTH * 4;
    localparam int LAT [2] = '{1, 3};

    logic        clk;
    logic        rst_n;
    logic        req_valid    [2];
    logic        req_ready    [2];
    logic        req_write    [2];
    logic [31:0] req_addr     [2];
    logic [1:0]  req_size     [2];
    logic        req_unsigned [2];
    logic [31:0] req_wdata    [2];
    logic        resp_valid   [2];
    logic        resp_ready   [2];
    logic [31:0] resp_rdata   [2];
    logic        resp_err     [2];

    int total = 0;
    int bad   = 0;
    int edge_n = 0;

    // Behavioural model: byte array plus one expected outstanding response.
    typedef struct {
        bit          pending;
        int          acc;
        logic [31:0] rd;
        bit          er;
    } mdl_t;

    logic [7:0] mm [2][MEM_BYTES];
    mdl_t       m  [2];

    data_memory_hs #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
        .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    data_memory_hs #(.DEPTH_WORDS(DEPTH), .LATENCY(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
        .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Apply one accepted request to the model: error rules, store, or load value.
    task automatic model_access(input int d);
        logic [31:0] a;
        int          nb;
        longint      v;
        bit          er;
        a  = req_addr[d];
        nb = 1 << req_size[d];
        er = (req_size[d] == 2'd3) ||
             (req_size[d] == 2'd1 && a[0]) ||
             (req_size[d] == 2'd2 && a[1:0] != 2'b00) ||
             (a >= 32'(MEM_BYTES));
        m[d].er = er;
        m[d].rd = 32'h0;
        if (!er) begin
            if (req_write[d]) begin
                for (int i = 0; i < nb; i++) mm[d][int'(a) + i] = 8'(req_wdata[d] >> (8 * i));
            end else begin
                v = 0;
                for (int i = 0; i < nb; i++) v += longint'(mm[d][int'(a) + i]) << (8 * i);
                if (!req_unsigned[d] && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
                    v -= longint'(1) << (8 * nb);
                m[d].rd = 32'(v);
            end
        end
    endtask

    // Model update at every rising edge from the observed inputs.
    initial begin
        for (int d = 0; d < 2; d++) begin
            m[d].pending = 1'b0;
            m[d].acc = 0;
            m[d].rd = 32'h0;
            m[d].er = 1'b0;
        end
        forever begin
            @(posedge clk);
            edge_n = edge_n + 1;
            for (int d = 0; d < 2; d++) begin
                if (!rst_n) begin
                    m[d].pending = 1'b0;
                end else if (m[d].pending) begin
                    if (edge_n >= m[d].acc + LAT[d] && resp_ready[d]) m[d].pending = 1'b0;
                end else if (req_valid[d]) begin
                    m[d].pending = 1'b1;
                    m[d].acc = edge_n;
                    model_access(d);
                end
            end
        end
    end

    // Compare DUT outputs against the model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                bit exp_valid;
                if (!rst_n) begin
                    check($sformatf("d%0d reset req_ready", d), 32'(req_ready[d]), 32'd1);
                    check($sformatf("d%0d reset resp_valid", d), 32'(resp_valid[d]), 32'd0);
                end else begin
                    exp_valid = m[d].pending && (edge_n >= m[d].acc + LAT[d] - 1);
                    check($sformatf("d%0d req_ready @%0d", d, edge_n), 32'(req_ready[d]), 32'(!m[d].pending));
                    check($sformatf("d%0d resp_valid @%0d", d, edge_n), 32'(resp_valid[d]), 32'(exp_valid));
                    if (exp_valid) begin
                        check($sformatf("d%0d resp_rdata @%0d", d, edge_n), resp_rdata[d], m[d].rd);
                        check($sformatf("d%0d resp_err @%0d", d, edge_n), 32'(resp_err[d]), 32'(m[d].er));
                    end
                end
            end
        end
    end

    // Present a request and hold it until accepted; returns just after the accepting edge.
    task automatic send_req(input int d, input bit wr, input logic [31:0] addr, input logic [1:0] size,
                            input bit uns, input logic [31:0] wdata, input string nm, output bit ok);
        int n;
        @(negedge clk); #1;
        req_valid[d]    = 1'b1;
        req_write[d]    = wr;
        req_addr[d]     = addr;
        req_size[d]     = size;
        req_unsigned[d] = uns;
        req_wdata[d]    = wdata;
        n = 0;
        while (!req_ready[d] && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        ok = req_ready[d];
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL %s: request not accepted within 20 cycles", nm);
        end
        @(posedge clk); #1;
        // Scramble the request fields: they must only matter at acceptance.
        req_valid[d]    = 1'b0;
        req_write[d]    = ~wr;
        req_addr[d]     = 32'hFFFF_FFFF;
        req_size[d]     = 2'd3;
        req_unsigned[d] = ~uns;
        req_wdata[d]    = 32'hFFFF_FFFF;
    endtask

    // One full transaction with hand-computed expected response and latency.
    task automatic xact(input int d, input bit wr, input logic [31:0] addr, input logic [1:0] size,
                        input bit uns, input logic [31:0] wdata, input int rr_hold,
                        input logic [31:0] exp_rd, input bit exp_er, input string nm);
        bit          ok;
        bit          got;
        int          n;
        int          h;
        int          lat;
        logic [31:0] rd;
        logic        er;
        resp_ready[d] = (rr_hold == 0);
        send_req(d, wr, addr, size, uns, wdata, nm, ok);
        if (!ok) return;
        got = 1'b0;
        h   = 0;
        lat = 0;
        rd  = 32'h0;
        er  = 1'b0;
        for (n = 1; n <= 30 && !got; n++) begin
            @(negedge clk); #1;
            if (resp_valid[d]) begin
                if (lat == 0) lat = n;
                if (h < rr_hold) begin
                    h++;
                end else begin
                    resp_ready[d] = 1'b1;
                    rd  = resp_rdata[d];
                    er  = resp_err[d];
                    got = 1'b1;
                    @(posedge clk); #1;
                    resp_ready[d] = 1'b0;
                end
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL %s: no response within 30 cycles", nm);
        end else begin
            check({nm, " latency"}, 32'(lat), 32'(LAT[d]));
            check({nm, " rdata"}, rd, exp_rd);
            check({nm, " err"}, 32'(er), 32'(exp_er));
        end
    endtask

    initial begin
        bit ok;
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_write[d] = 1'b0; req_addr[d] = 32'h0; req_size[d] = 2'd0;
            req_unsigned[d] = 1'b0; req_wdata[d] = 32'h0; resp_ready[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d post-reset req_ready", d), 32'(req_ready[d]), 32'd1);
            check($sformatf("d%0d post-reset resp_valid", d), 32'(resp_valid[d]), 32'd0);
            check($sformatf("d%0d post-reset resp_rdata", d), resp_rdata[d], 32'h0);
            check($sformatf("d%0d post-reset resp_err", d), 32'(resp_err[d]), 32'd0);
        end

        // Word load, sub-word loads with extension (LATENCY=1).
        xact(0, 1, 32'h12C, 2, 0, 32'hDEADBEEF, 0, 32'h0,        0, "preload 0x12C");
        xact(0, 0, 32'h12C, 2, 0, 32'h0,        0, 32'hDEADBEEF, 0, "lw 0x12C");
        xact(0, 0, 32'h12F, 0, 0, 32'h0,        0, 32'hFFFFFFDE, 0, "lb 0x12F");
        xact(0, 0, 32'h12C, 1, 1, 32'h0,        0, 32'h0000BEEF, 0, "lhu 0x12C");
        xact(0, 0, 32'h12E, 1, 0, 32'h0,        0, 32'hFFFFDEAD, 0, "lh 0x12E");
        xact(0, 0, 32'h12D, 0, 1, 32'h0,        0, 32'h000000BE, 0, "lbu 0x12D");

        // Byte and half stores merge into an existing word.
        xact(0, 1, 32'h130, 2, 0, 32'h12345678, 0, 32'h0,        0, "sw 0x130");
        xact(0, 1, 32'h131, 0, 0, 32'hFFFFFF5A, 0, 32'h0,        0, "sb 0x131");
        xact(0, 0, 32'h130, 2, 0, 32'h0,        0, 32'h12345A78, 0, "lw after sb");
        xact(0, 1, 32'h132, 1, 0, 32'h1234CAFE, 0, 32'h0,        0, "sh 0x132");
        xact(0, 0, 32'h130, 2, 0, 32'h0,        0, 32'hCAFE5A78, 0, "lw after sh");

        // Error cases.
        xact(0, 0, 32'h002, 2, 0, 32'h0,        0, 32'h0,        1, "lw misaligned");
        xact(0, 1, 32'h131, 1, 0, 32'h0000BEEF, 0, 32'h0,        1, "sh misaligned");
        xact(0, 0, 32'h130, 2, 0, 32'h0,        0, 32'hCAFE5A78, 0, "lw after bad sh");
        xact(0, 0, 32'h130, 3, 0, 32'h0,        0, 32'h0,        1, "size 3");
        xact(0, 0, 32'h400, 2, 0, 32'h0,        0, 32'h0,        1, "lw out of range");
        xact(0, 0, 32'h80000130, 2, 0, 32'h0,   0, 32'h0,        1, "lw high addr no wrap");

        // Last byte of the array is in range.
        xact(0, 1, 32'h3FF, 0, 0, 32'h00000080, 0, 32'h0,        0, "sb 0x3FF");
        xact(0, 0, 32'h3FF, 0, 0, 32'h0,        0, 32'hFFFFFF80, 0, "lb 0x3FF");

        // LATENCY=3 with the consumer stalling for 5 valid cycles.
        xact(1, 1, 32'h010, 2, 0, 32'h0BADF00D, 0, 32'h0,        0, "L3 sw 0x010");
        xact(1, 0, 32'h010, 2, 0, 32'h0,        5, 32'h0BADF00D, 0, "L3 lw stalled");
        xact(1, 0, 32'h012, 1, 0, 32'h0,        0, 32'h00000BAD, 0, "L3 lh 0x012");

        // Reset while a store sits in WAIT: response dropped, store kept.
        send_req(1, 1, 32'h180, 2, 0, 32'hAB0BAB0B, "L3 sw before reset", ok);
        @(negedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        check("post mid-reset resp_valid", 32'(resp_valid[1]), 32'd0);
        check("post mid-reset req_ready", 32'(req_ready[1]), 32'd1);
        repeat (6) @(negedge clk);
        #1 check("no stale response", 32'(resp_valid[1]), 32'd0);
        xact(1, 0, 32'h180, 2, 0, 32'h0,        0, 32'hAB0BAB0B, 0, "L3 lw after reset");

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
